hazard_bubble_ctrl: RTL and testbench

- Parametrised control/load hazard unit for the LC-3b pipeline, placed between the fetch-stage IR and the decode-stage IR.
- Classifies each fetched instruction as control (taken-capable BR, JMP, JSR, TRAP), load (LDR, LDB, LDI) or other.
- For control and load instructions, inserts a configurable number of NOP bubbles and freezes PC load while bubbles are active.
- Adds an early-resolution flush and saturating performance counters (bubbles and total cycles) with synchronous clear.

---
 rtl/hazard_bubble_ctrl_if.sv | 43 ++++
 rtl/hazard_bubble_ctrl.sv | 123 ++++++++++++
 tb/tb_hazard_bubble_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_bubble_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_bubble_ctrl_if
// Groups the fetch-to-decode signals of the LC-3b hazard bubble unit.
//   ir_in         fetched instruction (driven by fetch / bench)
//   stall         pipeline stall, freezes bubble state
//   flush         early control resolution, cancels remaining bubbles
//   cnt_clr       synchronous clear of both perf counters
//   ir_out        instruction handed to decode (NOP during a bubble)
//   pc_ld         PC load enable, low during a bubble
//   bubble_active high while bubbles remain
//   remaining     bubbles still to insert
//   bubble_cnt    saturating count of bubble cycles issued
//   cycle_cnt     saturating count of cycles since reset or clear
// master: the fetch side that drives ir_in/stall/flush/cnt_clr.
// slave : the hazard unit itself.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
interface hazard_bubble_ctrl_if #(
    parameter int WORD_W = 16,
    parameter int CNT_W  = 16,
    parameter int REM_W  = 2
);
    logic [WORD_W-1:0] ir_in;
    logic              stall;
    logic              flush;
    logic              cnt_clr;
    logic [WORD_W-1:0] ir_out;
    logic              pc_ld;
    logic              bubble_active;
    logic [REM_W-1:0]  remaining;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  cycle_cnt;

    modport master (
        output ir_in, stall, flush, cnt_clr,
        input  ir_out, pc_ld, bubble_active, remaining, bubble_cnt, cycle_cnt
    );

    modport slave (
        input  ir_in, stall, flush, cnt_clr,
        output ir_out, pc_ld, bubble_active, remaining, bubble_cnt, cycle_cnt
    );
endinterface

// File: rtl/hazard_bubble_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_bubble_ctrl
// Control/load hazard unit between the fetch IR and the decode IR of the LC-3b
// pipeline. Control instructions (taken-capable BR, JMP, JSR, TRAP) and loads
// (LDR, LDB, LDI) pass through, then a configurable number of all-zero NOP
// bubbles is inserted while PC load is frozen. A flush cancels pending bubbles.
// Two saturating counters report bubble cycles and total cycles.
// Ports:
//   clk      clock
//   reset_n  asynchronous active-low reset
//   bus      hazard_bubble_ctrl_if.slave (see the interface for the signal list)
// REM_W must match the REM_W of the connected interface.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module hazard_bubble_ctrl #(
    parameter int WORD_W       = 16,
    parameter int CTRL_BUBBLES = 1,
    parameter int LOAD_BUBBLES = 3,
    parameter int CNT_W        = 16,
    parameter int REM_W        =
        (((CTRL_BUBBLES > LOAD_BUBBLES) ? CTRL_BUBBLES : LOAD_BUBBLES) > 0)
            ? $clog2(((CTRL_BUBBLES > LOAD_BUBBLES) ? CTRL_BUBBLES : LOAD_BUBBLES) + 1)
            : 1
) (
    input logic                clk,
    input logic                reset_n,
    hazard_bubble_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        CLS_OTHER,
        CLS_CTRL,
        CLS_LOAD
    } ir_class_e;

    localparam logic [REM_W-1:0] CTRL_N  = REM_W'(CTRL_BUBBLES);
    localparam logic [REM_W-1:0] LOAD_N  = REM_W'(LOAD_BUBBLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [3:0]       opcode;
    logic [2:0]       nzp;
    ir_class_e        ir_class;

    logic [REM_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic             in_bubble;

    assign opcode    = bus.ir_in[WORD_W-1 -: 4];
    assign nzp       = bus.ir_in[WORD_W-5 -: 3];
    assign in_bubble = (remaining_q != '0);

    // BR with nzp=000 never branches, so it is treated as a plain NOP.
    // NOTE: every signal driven in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        ir_class = CLS_OTHER;
        unique case (opcode)
            4'b0000:                   ir_class = (nzp != 3'b000) ? CLS_CTRL : CLS_OTHER;
            4'b1100, 4'b0100, 4'b1111: ir_class = CLS_CTRL;
            4'b0110, 4'b0010, 4'b1010: ir_class = CLS_LOAD;
            default:                   ir_class = CLS_OTHER;
        endcase
    end

    // Next remaining in priority order: flush, stall, countdown, new sequence.
    // ir_in is only classified when no bubble is pending.
    always_comb begin
        remaining_d = '0;
        if (bus.flush) begin
            remaining_d = '0;
        end else if (bus.stall) begin
            remaining_d = remaining_q;
        end else if (in_bubble) begin
            remaining_d = remaining_q - REM_W'(1);
        end else if (ir_class == CLS_CTRL) begin
            remaining_d = CTRL_N;
        end else if (ir_class == CLS_LOAD) begin
            remaining_d = LOAD_N;
        end
    end

    // Counters saturate; clear overrides the increment in the same cycle.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        cycle_cnt_d  = cycle_cnt_q;
        if (bus.cnt_clr) begin
            bubble_cnt_d = '0;
            cycle_cnt_d  = '0;
        end else begin
            if (cycle_cnt_q != CNT_MAX) begin
                cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
            end
            if (in_bubble && !bus.stall && !bus.flush && (bubble_cnt_q != CNT_MAX)) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining_q  <= '0;
            bubble_cnt_q <= '0;
            cycle_cnt_q  <= '0;
        end else begin
            remaining_q  <= remaining_d;
            bubble_cnt_q <= bubble_cnt_d;
            cycle_cnt_q  <= cycle_cnt_d;
        end
    end

    // Outputs depend only on registered state (and ir_in for pass-through),
    // so an async reset takes effect without a clock edge.
    assign bus.ir_out        = in_bubble ? '0 : bus.ir_in;
    assign bus.pc_ld         = !in_bubble;
    assign bus.bubble_active = in_bubble;
    assign bus.remaining     = remaining_q;
    assign bus.bubble_cnt    = bubble_cnt_q;
    assign bus.cycle_cnt     = cycle_cnt_q;

endmodule

// File: tb/tb_hazard_bubble_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_bubble_ctrl
// Drives two instances of hazard_bubble_ctrl with identical stimulus: one with
// default parameters and one with CNT_W=4 to reach counter saturation. A
// queue-based model holds one token per pending bubble; a compare process
// checks both instances against it on every falling edge, and directed
// literal checks pin the model to hand-computed values.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hazard_bubble_ctrl;

    localparam int WORD_W = 16;
    localparam int CTRL_B = 1;
    localparam int LOAD_B = 3;
    localparam int REM_W  = 2;

    logic        clk;
    logic        reset_n;
    logic [15:0] ir;
    logic        stall;
    logic        flush;
    logic        cnt_clr;

    int total;
    int bad;

    hazard_bubble_ctrl_if #(.WORD_W(WORD_W), .CNT_W(16), .REM_W(REM_W)) if_d ();
    hazard_bubble_ctrl_if #(.WORD_W(WORD_W), .CNT_W(4),  .REM_W(REM_W)) if_4 ();

    assign if_d.ir_in   = ir;
    assign if_d.stall   = stall;
    assign if_d.flush   = flush;
    assign if_d.cnt_clr = cnt_clr;
    assign if_4.ir_in   = ir;
    assign if_4.stall   = stall;
    assign if_4.flush   = flush;
    assign if_4.cnt_clr = cnt_clr;

    hazard_bubble_ctrl #(
        .WORD_W(WORD_W), .CTRL_BUBBLES(CTRL_B), .LOAD_BUBBLES(LOAD_B), .CNT_W(16)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(if_d)
    );

    hazard_bubble_ctrl #(
        .WORD_W(WORD_W), .CTRL_BUBBLES(CTRL_B), .LOAD_BUBBLES(LOAD_B), .CNT_W(4)
    ) u_dut4 (
        .clk(clk), .reset_n(reset_n), .bus(if_4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Bubbles to schedule for an instruction, straight from the ISA classes.
    function automatic int bubbles_for(input logic [15:0] w);
        int n;
        n = 0;
        case (w[15:12])
            4'h0:             n = (w[11:9] != 3'b000) ? CTRL_B : 0;
            4'hC, 4'h4, 4'hF: n = CTRL_B;
            4'h6, 4'h2, 4'hA: n = LOAD_B;
            default:          n = 0;
        endcase
        return n;
    endfunction

    bit     pend[$];   // one entry per bubble still owed
    longint cyc_m;
    longint bub_m;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend.delete();
            cyc_m <= 0;
            bub_m <= 0;
        end else begin
            if (cnt_clr) begin
                cyc_m <= 0;
                bub_m <= 0;
            end else begin
                cyc_m <= cyc_m + 1;
                if (pend.size() != 0 && !stall && !flush) bub_m <= bub_m + 1;
            end
            if (flush) begin
                pend.delete();
            end else if (!stall) begin
                if (pend.size() != 0) void'(pend.pop_front());
                else repeat (bubbles_for(ir)) pend.push_back(1'b1);
            end
        end
    end

    function automatic longint sat(input longint v, input int w);
        longint mx;
        mx = (longint'(1) << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (reset_n) begin
            int r;
            r = pend.size();
            check("rem",        32'(if_d.remaining),     32'(r));
            check("active",     32'(if_d.bubble_active), 32'(r != 0));
            check("pc_ld",      32'(if_d.pc_ld),         32'(r == 0));
            check("ir_out",     32'(if_d.ir_out),        (r != 0) ? 32'h0 : 32'(ir));
            check("bub_cnt",    32'(if_d.bubble_cnt),    32'(sat(bub_m, 16)));
            check("cyc_cnt",    32'(if_d.cycle_cnt),     32'(sat(cyc_m, 16)));
            check("rem4",       32'(if_4.remaining),     32'(r));
            check("pc_ld4",     32'(if_4.pc_ld),         32'(r == 0));
            check("ir_out4",    32'(if_4.ir_out),        (r != 0) ? 32'h0 : 32'(ir));
            check("bub_cnt4",   32'(if_4.bubble_cnt),    32'(sat(bub_m, 4)));
            check("cyc_cnt4",   32'(if_4.cycle_cnt),     32'(sat(cyc_m, 4)));
        end
    end

    // ---------------- stimulus helpers ----------------
    // Inputs change 1 ns after the rising edge; literal checks run 3 ns after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input logic [15:0] w, input logic st, input logic fl, input logic clr);
        ir      = w;
        stall   = st;
        flush   = fl;
        cnt_clr = clr;
        #2;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
    endtask

    localparam logic [15:0] ADD = 16'h1021;
    localparam logic [15:0] LDR = 16'h6042;

    // Mixed directed sequence for model-only checking: instr, stall, flush.
    logic [15:0] mix_ir [12] = '{16'hA042, ADD, ADD, 16'h2042, ADD, 16'h4800,
                                 16'hF025, ADD, 16'hC1C0, ADD, 16'h0E02, ADD};
    bit          mix_st [12] = '{0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    bit          mix_fl [12] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0};
    bit          st_pat [6]  = '{0, 1, 1, 0, 0, 0};

    initial begin
        int nbub;
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        ir      = ADD;
        stall   = 1'b0;
        flush   = 1'b0;
        cnt_clr = 1'b0;
        tick();
        reset_n = 1'b1;
        apply(ADD, 0, 0, 0);
        check("reset_rem",   32'(if_d.remaining),  32'd0);
        check("reset_pc_ld", 32'(if_d.pc_ld),      32'd1);
        check("reset_bcnt",  32'(if_d.bubble_cnt), 32'd0);
        check("reset_ccnt",  32'(if_d.cycle_cnt),  32'd0);
        tick();

        // Taken-capable BR: one bubble.
        do_reset();
        apply(16'h0E02, 0, 0, 0);
        check("br_c0_ir",  32'(if_d.ir_out), 32'h0E02);
        check("br_c0_pc",  32'(if_d.pc_ld),  32'd1);
        tick();
        apply(ADD, 0, 0, 0);
        check("br_c1_ir",  32'(if_d.ir_out),    32'h0);
        check("br_c1_pc",  32'(if_d.pc_ld),     32'd0);
        check("br_c1_rem", 32'(if_d.remaining), 32'd1);
        tick();
        apply(ADD, 0, 0, 0);
        check("br_c2_ir",  32'(if_d.ir_out),     32'h1021);
        check("br_c2_pc",  32'(if_d.pc_ld),      32'd1);
        check("br_bcnt",   32'(if_d.bubble_cnt), 32'd1);
        tick();

        // BR nzp=000 is a NOP: no bubble.
        do_reset();
        apply(16'h0002, 0, 0, 0);
        check("nop_pc0", 32'(if_d.pc_ld), 32'd1);
        tick();
        apply(ADD, 0, 0, 0);
        check("nop_pc1",  32'(if_d.pc_ld),      32'd1);
        check("nop_bcnt", 32'(if_d.bubble_cnt), 32'd0);
        tick();

        // LDR: three bubbles counting 3,2,1.
        do_reset();
        apply(LDR, 0, 0, 0);
        check("ldr_pass", 32'(if_d.ir_out), 32'h6042);
        tick();
        for (int i = 0; i < 3; i++) begin
            apply(ADD, 0, 0, 0);
            check("ldr_ir",  32'(if_d.ir_out),    32'h0);
            check("ldr_pc",  32'(if_d.pc_ld),     32'd0);
            check("ldr_rem", 32'(if_d.remaining), 32'(3 - i));
            tick();
        end
        apply(ADD, 0, 0, 0);
        check("ldr_resume", 32'(if_d.ir_out),     32'h1021);
        check("ldr_bcnt",   32'(if_d.bubble_cnt), 32'd3);
        tick();

        // LDR with a two-cycle stall while remaining=2.
        do_reset();
        apply(LDR, 0, 0, 0);
        tick();
        nbub = 0;
        for (int i = 0; i < 6; i++) begin
            apply(ADD, st_pat[i], 0, 0);
            if (!if_d.pc_ld) nbub++;
            if (st_pat[i]) begin
                check("stall_rem",  32'(if_d.remaining),  32'd2);
                check("stall_bcnt", 32'(if_d.bubble_cnt), 32'd1);
            end
            tick();
        end
        check("stall_nbub", 32'(nbub), 32'd5);
        apply(ADD, 0, 0, 0);
        check("stall_bcnt_end", 32'(if_d.bubble_cnt), 32'd3);
        tick();

        // Flush beats stall on the first bubble cycle.
        do_reset();
        apply(LDR, 0, 0, 0);
        tick();
        apply(ADD, 1, 1, 0);
        check("flush_rem0", 32'(if_d.remaining), 32'd3);
        tick();
        apply(ADD, 0, 0, 0);
        check("flush_rem",  32'(if_d.remaining),  32'd0);
        check("flush_pc",   32'(if_d.pc_ld),      32'd1);
        check("flush_bcnt", 32'(if_d.bubble_cnt), 32'd0);
        tick();
        // Flush with a JMP at remaining=0 starts no sequence.
        apply(16'hC1C0, 0, 1, 0);
        tick();
        apply(ADD, 0, 0, 0);
        check("flush_jmp_rem", 32'(if_d.remaining), 32'd0);
        tick();

        // Mixed sequence, checked by the model on every cycle.
        for (int i = 0; i < 12; i++) begin
            apply(mix_ir[i], mix_st[i], mix_fl[i], 0);
            tick();
        end

        // Counter saturation with CNT_W=4 and synchronous clear.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            apply(ADD, 0, 0, 0);
            tick();
        end
        apply(ADD, 0, 0, 1);
        check("sat4_ccnt",  32'(if_4.cycle_cnt), 32'd15);
        check("sat16_ccnt", 32'(if_d.cycle_cnt), 32'd20);
        tick();
        apply(ADD, 0, 0, 0);
        check("clr_ccnt4", 32'(if_4.cycle_cnt), 32'd0);
        check("clr_ccnt",  32'(if_d.cycle_cnt), 32'd0);
        tick();

        // Async reset mid-LDR takes effect without a clock edge.
        apply(LDR, 0, 0, 0);
        tick();
        apply(ADD, 0, 0, 0);
        check("arst_pre_rem", 32'(if_d.remaining), 32'd3);
        reset_n = 1'b0;
        #1;
        check("arst_rem",    32'(if_d.remaining),     32'd0);
        check("arst_pc",     32'(if_d.pc_ld),         32'd1);
        check("arst_active", 32'(if_d.bubble_active), 32'd0);
        check("arst_ir",     32'(if_d.ir_out),        32'h1021);
        tick();
        reset_n = 1'b1;
        apply(ADD, 0, 0, 0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
